// File: rtl/snake_pkg.sv
// Encodings and small helpers shared by the snake controller, snake datapath and display.
package snake_pkg;

    typedef enum logic [1:0] {
        PAUSED       = 2'b00,
        PLAYING      = 2'b01,
        DIE_FLASHING = 2'b10,
        INITIALIZING = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_e;

    localparam int NUM_APPLES = 5;

    function automatic logic [2:0] count_apples(input logic [NUM_APPLES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_APPLES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'b000000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Apple handshake bundle between the controller, the snake (eaten flags) and the apple generator.
interface snake_game_ctrl_if;
    import snake_pkg::*;

    logic [NUM_APPLES-1:0] get_apple;
    logic [NUM_APPLES-1:0] respawn_ack;
    logic [NUM_APPLES-1:0] respawn_req;

    modport master (input get_apple, input respawn_ack, output respawn_req);
    modport slave  (output get_apple, output respawn_ack, input respawn_req);

endinterface

// File: rtl/btn_edge.sv
// Registered rising-edge detector: pulses for one clock, one clock after the input rises.
module btn_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
            rise_q <= btn_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: status FSM, death-flash timer, direction arbitration and apple scoring handshake.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int FLASH_CYCLES = 40000000,
    parameter int FLASH_COUNT  = 3,
    parameter int INIT_CYCLES  = 4,
    parameter int WIN_SCORE    = 29
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                btn_start,
    input  logic                btn_pause,
    input  logic [3:0]          btn_dir,
    input  logic [1:0]          current_direction,
    input  logic                hit_wall,
    input  logic                hit_itself,
    snake_game_ctrl_if.master   apple,
    output logic [1:0]          game_status,
    output logic [1:0]          next_direction,
    output logic [7:0]          score,
    output logic                game_won
);

    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int PW = (FLASH_COUNT  > 1) ? $clog2(FLASH_COUNT)  : 1;
    localparam int IW = (INIT_CYCLES  > 1) ? $clog2(INIT_CYCLES)  : 1;

    logic                  start_edge;
    logic                  pause_edge;
    logic [3:0]            dir_edge;
    logic [NUM_APPLES-1:0] apple_edge;
    logic [NUM_APPLES-1:0] take;
    logic [NUM_APPLES-1:0] req_q, req_d;
    logic                  hit;
    logic                  scoring;

    status_e        state_q, state_d;
    dir_e           dir_q, dir_d;
    dir_e           cand;
    logic [7:0]     score_q, score_d, score_sum;
    logic           won_q, won_d;
    logic [FW-1:0]  flash_cyc_q, flash_cyc_d;
    logic [PW-1:0]  flash_per_q, flash_per_d;
    logic [IW-1:0]  init_cnt_q, init_cnt_d;

    assign hit     = hit_wall | hit_itself;
    assign scoring = (state_q == PLAYING) && !hit;

    btn_edge u_start_edge (.clock(clock), .reset_n(reset_n), .btn_i(btn_start), .rise_o(start_edge));
    btn_edge u_pause_edge (.clock(clock), .reset_n(reset_n), .btn_i(btn_pause), .rise_o(pause_edge));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dir
            btn_edge u_dir_edge (.clock(clock), .reset_n(reset_n), .btn_i(btn_dir[gi]), .rise_o(dir_edge[gi]));
        end

        // The pending request doubles as the mask: further eats of that apple are ignored until acked.
        for (genvar gi = 0; gi < NUM_APPLES; gi++) begin : g_apple
            btn_edge u_apple_edge (.clock(clock), .reset_n(reset_n), .btn_i(apple.get_apple[gi]), .rise_o(apple_edge[gi]));
            assign take[gi]  = scoring && apple_edge[gi] && !req_q[gi];
            assign req_d[gi] = take[gi] ? 1'b1 : (apple.respawn_ack[gi] ? 1'b0 : req_q[gi]);
        end
    endgenerate

    always_comb begin
        if (dir_edge[0])      cand = UP;
        else if (dir_edge[1]) cand = RIGHT;
        else if (dir_edge[2]) cand = DOWN;
        else                  cand = LEFT;
    end

    assign score_sum = sat_add(score_q, count_apples(take));

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        score_d     = score_q;
        won_d       = won_q;
        flash_cyc_d = '0;
        flash_per_d = '0;
        init_cnt_d  = '0;

        case (state_q)
            INITIALIZING: begin
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) state_d = PAUSED;
                else                                     init_cnt_d = init_cnt_q + 1'b1;
            end
            PAUSED: begin
                if (start_edge)                  state_d = won_q ? INITIALIZING : PLAYING;
                else if (pause_edge && !won_q)   state_d = PLAYING;
            end
            PLAYING: begin
                if ((|dir_edge) && (cand != dir_e'(current_direction ^ 2'b10))) dir_d = cand;
                if (hit) begin
                    state_d = DIE_FLASHING;
                end else begin
                    score_d = score_sum;
                    if (int'(score_sum) >= WIN_SCORE) begin
                        won_d   = 1'b1;
                        state_d = PAUSED;
                    end else if (pause_edge) begin
                        state_d = PAUSED;
                    end
                end
            end
            DIE_FLASHING: begin
                if (start_edge) begin
                    state_d = INITIALIZING;
                end else begin
                    flash_cyc_d = flash_cyc_q + 1'b1;
                    flash_per_d = flash_per_q;
                    if (flash_cyc_q == FW'(FLASH_CYCLES - 1)) begin
                        flash_cyc_d = '0;
                        if (flash_per_q == PW'(FLASH_COUNT - 1)) state_d = INITIALIZING;
                        else                                      flash_per_d = flash_per_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Clearing on entry means the first INITIALIZING cycle already shows a fresh game.
        if (state_d == INITIALIZING) begin
            score_d = '0;
            won_d   = 1'b0;
            dir_d   = RIGHT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= INITIALIZING;
            dir_q       <= RIGHT;
            score_q     <= '0;
            won_q       <= 1'b0;
            req_q       <= '0;
            flash_cyc_q <= '0;
            flash_per_q <= '0;
            init_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            score_q     <= score_d;
            won_q       <= won_d;
            req_q       <= (state_d == INITIALIZING) ? '0 : req_d;
            flash_cyc_q <= flash_cyc_d;
            flash_per_q <= flash_per_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    assign game_status       = state_q;
    assign next_direction    = dir_q;
    assign score             = score_q;
    assign game_won          = won_q;
    assign apple.respawn_req = req_q;

endmodule
